// File: rtl/ti_quad_pkg.sv
// Shared helpers for the TI quadratic layer: mask indexing, ANF evaluation
// of one degree-2 Boolean function, and the default identity linear mask.
package ti_quad_pkg;

  localparam int MAX_IN  = 16;
  localparam int MAX_OUT = 32;

  function automatic int lin_idx(input int k, input int i, input int n_in);
    return k * n_in + i;
  endfunction

  function automatic int quad_idx(input int k, input int i, input int j, input int n_in);
    return (k * n_in + i) * n_in + j;
  endfunction

  function automatic logic [MAX_OUT*MAX_IN-1:0] lin_identity(input int n_out, input int n_in);
    logic [MAX_OUT*MAX_IN-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_OUT; k++)
      if (k < n_out && k < n_in) r[lin_idx(k, k, n_in)] = 1'b1;
    return r;
  endfunction

  // quad is one function's N_IN x N_IN row (stride n_in); only i<j terms count.
  function automatic logic eval_quad(input logic [MAX_IN-1:0]        x,
                                     input logic                     c,
                                     input logic [MAX_IN-1:0]        lin,
                                     input logic [MAX_IN*MAX_IN-1:0] quad,
                                     input int                       n_in);
    logic f;
    f = c;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < n_in) begin
        f = f ^ (lin[i] & x[i]);
        for (int j = i + 1; j < MAX_IN; j++)
          if (j < n_in) f = f ^ (quad[i*n_in+j] & x[i] & x[j]);
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/ti_quad_eval.sv
// Combinational share-function evaluator: one degree-2 ANF per output bit,
// coefficients fixed at elaboration.
module ti_quad_eval
  import ti_quad_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_OUT = 8,
  parameter logic [N_OUT-1:0]           CONST_MASK = '0,
  parameter logic [N_OUT*N_IN-1:0]      LIN_MASK   = '0,
  parameter logic [N_OUT*N_IN*N_IN-1:0] QUAD_MASK  = '0
) (
  input  logic [N_IN-1:0]  in_data,
  output logic [N_OUT-1:0] f
);

  logic [MAX_IN-1:0] x_ext;
  assign x_ext = MAX_IN'(in_data);

  for (genvar k = 0; k < N_OUT; k++) begin : g_f
    localparam logic [MAX_IN-1:0] LIN_ROW =
      MAX_IN'(LIN_MASK[lin_idx(k, 0, N_IN) +: N_IN]);
    localparam logic [MAX_IN*MAX_IN-1:0] QUAD_ROW =
      (MAX_IN*MAX_IN)'(QUAD_MASK[quad_idx(k, 0, 0, N_IN) +: N_IN*N_IN]);
    assign f[k] = eval_quad(x_ext, CONST_MASK[k], LIN_ROW, QUAD_ROW, N_IN);
  end

endmodule

// File: rtl/ti_quad_layer_pipe.sv
// One TI quadratic layer: share functions, register barrier, optional
// refresh from fresh randomness, two-stage elastic valid/ready pipe.
module ti_quad_layer_pipe
  import ti_quad_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int SH_W    = 4,
  parameter int NSH_OUT = 2,
  parameter logic [NSH_OUT*SH_W-1:0]           CONST_MASK = '0,
  parameter logic [NSH_OUT*SH_W*N_IN-1:0]      LIN_MASK   =
    (NSH_OUT*SH_W*N_IN)'(lin_identity(NSH_OUT*SH_W, N_IN)),
  parameter logic [NSH_OUT*SH_W*N_IN*N_IN-1:0] QUAD_MASK  = '0,
  parameter int REMASK  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_IN-1:0]             in_data,
  input  logic [(NSH_OUT-1)*SH_W-1:0] rnd,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NSH_OUT*SH_W-1:0]     out_data,
  output logic [15:0]                 beat_cnt
);

  localparam int N_OUT = NSH_OUT * SH_W;
  localparam int RND_W = (NSH_OUT - 1) * SH_W;

  logic [N_OUT-1:0] f, s1_data, s2_data, mask;
  logic [RND_W-1:0] s1_rnd;
  logic             s1_valid, s2_valid, s2_adv, accept, out_xfer;

  ti_quad_eval #(
    .N_IN      (N_IN),
    .N_OUT     (N_OUT),
    .CONST_MASK(CONST_MASK),
    .LIN_MASK  (LIN_MASK),
    .QUAD_MASK (QUAD_MASK)
  ) u_eval (
    .in_data(in_data),
    .f      (f)
  );

  // Last share absorbs the XOR of all other masks so the shared value is preserved.
  always_comb begin
    mask = '0;
    if (REMASK != 0) begin
      for (int s = 0; s < NSH_OUT - 1; s++) begin
        mask[s*SH_W +: SH_W] = s1_rnd[s*SH_W +: SH_W];
        mask[(NSH_OUT-1)*SH_W +: SH_W] = mask[(NSH_OUT-1)*SH_W +: SH_W] ^ s1_rnd[s*SH_W +: SH_W];
      end
    end
  end

  assign s2_adv    = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !flush && (!s1_valid || s2_adv);
  assign accept    = in_valid && in_ready;
  assign out_xfer  = s2_valid && out_ready;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  // Emptied stages are zeroised so no stale shares or randomness linger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_data  <= '0;
      s1_rnd   <= '0;
      s2_data  <= '0;
      beat_cnt <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_data  <= '0;
      s1_rnd   <= '0;
      s2_data  <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_data  <= f;
        s1_rnd   <= rnd;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
        s1_rnd   <= '0;
      end
      if (s2_adv) begin
        s2_valid <= 1'b1;
        s2_data  <= s1_data ^ mask;
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end
      if (out_xfer) beat_cnt <= beat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ti_quad_layer_pipe.sv
// Bench: three configurations driven in lockstep, checked every cycle against
// a queue-based reference, plus hand-computed directed expectations.
module tb_ti_quad_layer_pipe;

  logic       clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic [3:0] rnd = '0;
  logic       ir [3];
  logic       ov [3];
  logic [7:0] od [3];
  logic [15:0] bc [3];

  int checks = 0, errors = 0;

  localparam logic [63:0]  LIN_ID = 64'h8040201008040201;
  localparam logic [63:0]  LIN_Q  = 64'h804020100804020D;
  // Function 0 pairs from the directed case, an ignored i>j bit (2,1), and two pairs in function 5.
  localparam logic [511:0] QUAD_Q =
    (512'd1 << 10) | (512'd1 << 28) | (512'd1 << 2)  | (512'd1 << 11) |
    (512'd1 << 20) | (512'd1 << 29) | (512'd1 << 3)  | (512'd1 << 21) |
    (512'd1 << 14) | (512'd1 << 6)  | (512'd1 << 15) | (512'd1 << 7)  |
    (512'd1 << 17) | (512'd1 << 321) | (512'd1 << 375);
  localparam logic [7:0] CONST_Q = 8'h40;

  always #5 clk = ~clk;

  ti_quad_layer_pipe #(.REMASK(0)) u_id0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .rnd(rnd), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .beat_cnt(bc[0]));

  ti_quad_layer_pipe u_id1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .rnd(rnd), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .beat_cnt(bc[1]));

  ti_quad_layer_pipe #(.CONST_MASK(CONST_Q), .LIN_MASK(LIN_Q), .QUAD_MASK(QUAD_Q), .REMASK(0)) u_q (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .rnd(rnd), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .beat_cnt(bc[2]));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fmodel(input logic [7:0] x, input logic [7:0] c,
                                        input logic [63:0] lin, input logic [511:0] quad);
    logic [7:0] y;
    for (int k = 0; k < 8; k++) begin
      y[k] = c[k] ^ (^(lin[k*8 +: 8] & x));
      for (int i = 0; i < 8; i++)
        for (int j = i + 1; j < 8; j++)
          y[k] = y[k] ^ (quad[k*64 + i*8 + j] & x[i] & x[j]);
    end
    return y;
  endfunction

  typedef struct { logic [2:0][7:0] d; int age; } ent_t;
  ent_t        q[$];
  logic [15:0] mcnt = '0;
  logic        mir, mov;
  ent_t        e;

  always @(negedge rst_n) begin
    q.delete();
    mcnt = '0;
  end

  // Reference: in-order queue of held beats; a beat is presentable one edge after entry.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt = '0;
      for (int j = 0; j < 3; j++) begin
        chk("rst_out_valid", 16'(ov[j]), 16'd0);
        chk("rst_beat_cnt", bc[j], 16'd0);
      end
    end else begin
      mir = !flush && (q.size() < 2 || out_ready);
      mov = q.size() > 0 && q[0].age >= 1;
      for (int j = 0; j < 3; j++) begin
        chk("mdl_in_ready", 16'(ir[j]), 16'(mir));
        chk("mdl_out_valid", 16'(ov[j]), 16'(mov));
        chk("mdl_out_data", 16'(od[j]), mov ? 16'(q[0].d[j]) : 16'd0);
        chk("mdl_beat_cnt", bc[j], mcnt);
      end
      if (flush) q.delete();
      else begin
        if (mov && out_ready) begin
          void'(q.pop_front());
          mcnt = mcnt + 16'd1;
        end
        foreach (q[i]) q[i].age++;
        if (in_valid && mir) begin
          e.d[0] = fmodel(in_data, 8'h00, LIN_ID, '0);
          e.d[1] = fmodel(in_data, 8'h00, LIN_ID, '0) ^ {rnd, rnd};
          e.d[2] = fmodel(in_data, CONST_Q, LIN_Q, QUAD_Q);
          e.age  = 0;
          q.push_back(e);
        end
      end
    end
  end

  // One beat with out_ready high; returns at the negedge where it is presented.
  task automatic beat(input logic [7:0] x, input logic [3:0] r);
    @(posedge clk); #1 in_valid = 1'b1; in_data = x; rnd = r;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("lat1_out_valid", 16'(ov[0]), 16'd0);
    @(posedge clk);
    @(negedge clk); chk("lat2_out_valid", 16'(ov[0]), 16'd1);
  endtask

  int  sent;
  logic acc;

  initial begin
    #8;
    chk("reset_in_ready", 16'(ir[0]), 16'd1);
    chk("reset_out_valid", 16'(ov[0]), 16'd0);
    chk("reset_beat_cnt", bc[0], 16'd0);
    #4 rst_n = 1'b1;
    out_ready = 1'b1;

    beat(8'hA5, 4'h9);
    chk("ident_a5", 16'(od[0]), 16'h00A5);
    chk("remask_a5", 16'(od[1]), 16'h003C);
    beat(8'h3C, 4'h9);
    chk("remask_3c", 16'(od[1]), 16'h00A5);
    chk("share_xor", 16'(od[1][7:4] ^ od[1][3:0]), 16'h000F);
    chk("ident_3c", 16'(od[0]), 16'h003C);
    beat(8'h01, 4'h0); chk("quad_01", 16'(od[2][0]), 16'd1);
    beat(8'h05, 4'h0); chk("quad_05", 16'(od[2][0]), 16'd1);
    beat(8'h0C, 4'h0); chk("quad_0c", 16'(od[2][0]), 16'd0);
    @(posedge clk); @(negedge clk);
    chk("cnt_after_5", bc[0], 16'd5);

    // Back-pressure: sink stalled for four cycles while the source streams.
    out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'hB0; sent = 0;
    for (int c = 0; c < 16 && sent < 4; c++) begin
      @(negedge clk);
      acc = ir[0];
      if (c == 2 || c == 3) begin
        chk("bp_in_ready_low", 16'(ir[0]), 16'd0);
        chk("bp_hold_data", 16'(od[0]), 16'h00B0);
      end
      @(posedge clk); #1;
      if (acc) begin sent++; in_data = 8'hB0 + 8'(sent); end
      if (sent == 4) in_valid = 1'b0;
      if (c == 3) out_ready = 1'b1;
    end
    chk("bp_all_sent", 16'(sent), 16'd4);
    repeat (6) @(negedge clk);
    chk("bp_cnt", bc[0], 16'd9);

    // Flush with both stages full and a beat presented the same cycle.
    out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'hC1;
    @(posedge clk); #1 in_data = 8'hC2;
    @(posedge clk); #1 in_data = 8'hC3; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 16'(ir[0]), 16'd0);
    chk("flush_full", 16'(ov[0]), 16'd1);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flushed_valid", 16'(ov[0]), 16'd0);
    chk("flushed_data", 16'(od[0]), 16'd0);
    chk("flushed_cnt", bc[0], 16'd9);
    beat(8'hD4, 4'h0);
    chk("post_flush_data", 16'(od[0]), 16'h00D4);
    @(posedge clk); @(negedge clk);
    chk("post_flush_cnt", bc[0], 16'd10);

    // Randomised traffic with an asynchronous reset pulse mid-stream.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      in_data   = 8'($urandom);
      rnd       = 4'($urandom);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      if (n == 1500) begin
        flush = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 16'(ov[0]), 16'd0);
        chk("async_rst_cnt", bc[0], 16'd0);
        chk("async_rst_in_ready", 16'(ir[0]), 16'd1);
        #1 rst_n = 1'b1;
      end
    end
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("drain_valid", 16'(ov[0]), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
